// File: rtl/regfile_2r1w_pkg.sv
// Shared constants and FSM encoding for the 2R1W architectural register file.
// Zero-cycle reads, no backpressure; REGFILE_BYPASS_EN selects write-to-read forwarding in the read ports.
package regfile_2r1w_pkg;

   localparam int REG_NUM      = 32;
   localparam int REG_NUM_LOG2 = 5;
   localparam int REG_BUS_W    = 32;

   localparam logic [REG_BUS_W-1:0]    ZERO_WORD    = '0;
   localparam logic [REG_NUM_LOG2-1:0] NOP_REG_ADDR = '0;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Decode/write-back side bundle of the register file: one write port, two read ports, ready flag.
// Reads are combinational; ready_o low means the pipeline must stall.
interface regfile_2r1w_if
   import regfile_2r1w_pkg::*;
#(
   parameter int DATA_W = REG_BUS_W,
   parameter int ADDR_W = REG_NUM_LOG2
);

   logic              we_i;
   logic [ADDR_W-1:0] waddr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              re1_i;
   logic [ADDR_W-1:0] raddr1_i;
   logic [DATA_W-1:0] rdata1_o;
   logic              re2_i;
   logic [ADDR_W-1:0] raddr2_i;
   logic [DATA_W-1:0] rdata2_o;
   logic              ready_o;

   modport master (
      output we_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i,
      input  rdata1_o, rdata2_o, ready_o
   );

   modport slave (
      input  we_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i,
      output rdata1_o, rdata2_o, ready_o
   );

endinterface

// File: rtl/regfile_2r1w_rdport.sv
// One read port mux: zero for reset/disabled/r0/INIT, else array data (or write data when REGFILE_BYPASS_EN).
// Purely combinational, no backpressure.
module regfile_2r1w_rdport #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              i_rst_n,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   input  logic              i_init,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic w_byp_hit;

`ifdef REGFILE_BYPASS_EN
   assign w_byp_hit = i_we && (i_waddr != '0) && (i_waddr == i_raddr);
`else
   logic w_unused;
   assign w_byp_hit = 1'b0;
   assign w_unused  = ^{i_we, i_waddr, i_wdata};
`endif

   // Zero conditions come first so an unswept (X) array entry can never reach the output.
   always_comb begin
      o_rdata = '0;
      if (!i_rst_n || !i_re || (i_raddr == '0) || i_init) begin
         o_rdata = '0;
      end else if (w_byp_hit) begin
         o_rdata = i_wdata;
      end else begin
         o_rdata = i_mem_rdata;
      end
   end

endmodule

// File: rtl/regfile_2r1w.sv
// MIPS32 GPR file, 2 combinational reads + 1 write per clk; after reset a sweep zero-fills r1..r31 while ready_o=0.
// Writes during the sweep are dropped; REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_2r1w
   import regfile_2r1w_pkg::*;
#(
   parameter int DATA_W   = REG_BUS_W,
   parameter int ADDR_W   = REG_NUM_LOG2,
   parameter int NUM_REGS = REG_NUM
) (
   input  logic          clk,
   input  logic          rst,
   regfile_2r1w_if.slave bus
);

   logic [DATA_W-1:0] r_mem [NUM_REGS];
   state_e            r_state;
   state_e            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              w_init;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_waddr;
   logic [DATA_W-1:0] w_mem_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_INIT;
         r_cnt   <= ADDR_W'(1);
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // r0 is never stored, so the sweep starts at 1 and parks on the last register.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_INIT: begin
            if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
               w_state_nxt = ST_READY;
            end else begin
               w_cnt_nxt = r_cnt + ADDR_W'(1);
            end
         end
         ST_READY: w_state_nxt = ST_READY;
         default:  w_state_nxt = ST_INIT;
      endcase
   end

   assign w_init      = (r_state == ST_INIT);
   assign w_mem_we    = rst && (w_init || (bus.we_i && (bus.waddr_i != NOP_REG_ADDR)));
   assign w_mem_waddr = w_init ? r_cnt : bus.waddr_i;
   assign w_mem_wdata = w_init ? DATA_W'(ZERO_WORD) : bus.wdata_i;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   assign bus.ready_o = !w_init;

   regfile_2r1w_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport1 (
      .i_rst_n     (rst),
      .i_re        (bus.re1_i),
      .i_raddr     (bus.raddr1_i),
      .i_init      (w_init),
      .i_we        (bus.we_i),
      .i_waddr     (bus.waddr_i),
      .i_wdata     (bus.wdata_i),
      .i_mem_rdata (r_mem[bus.raddr1_i]),
      .o_rdata     (bus.rdata1_o)
   );

   regfile_2r1w_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport2 (
      .i_rst_n     (rst),
      .i_re        (bus.re2_i),
      .i_raddr     (bus.raddr2_i),
      .i_init      (w_init),
      .i_we        (bus.we_i),
      .i_waddr     (bus.waddr_i),
      .i_wdata     (bus.wdata_i),
      .i_mem_rdata (r_mem[bus.raddr2_i]),
      .o_rdata     (bus.rdata2_o)
   );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: stimulus queues expected outputs, a negedge monitor pops and compares.
// Covers the init sweep, write/read, r0, same-cycle write/read (both build options), INIT writes, async reset.
module tb_regfile_2r1w;

   localparam int DW = 32;
   localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] R7_SAME = 32'h0000_1234;
`else
   localparam logic [31:0] R7_SAME = 32'h0000_0001;
`endif

   localparam int K_RD1   = 0;
   localparam int K_RD2   = 1;
   localparam int K_READY = 2;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_errors;
   bit   done;
   bit   done_chk;
   exp_t q[$];

   regfile_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.we_i    = we;
      bus.waddr_i = a;
      bus.wdata_i = d;
   endtask

   task automatic rd(input logic re1, input logic [AW-1:0] a1, input logic re2, input logic [AW-1:0] a2);
      bus.re1_i    = re1;
      bus.raddr1_i = a1;
      bus.re2_i    = re2;
      bus.raddr2_i = a2;
   endtask

   task automatic expect_out(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      q.push_back(e);
   endtask

   // Monitor: compares every entry queued for the current cycle at the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         case (e.kind)
            K_RD1:   act = bus.rdata1_o;
            K_RD2:   act = bus.rdata2_o;
            default: act = {31'b0, bus.ready_o};
         endcase
         n_checks++;
         if (e.cyc != cyc) begin
            n_errors++;
            $display("FAIL %s: queued for cycle %0d, seen at cycle %0d", e.name, e.cyc, cyc);
         end else if (act !== e.val) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.val);
         end
      end
      if (done && !done_chk) begin
         done_chk = 1'b1;
         n_checks++;
         if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      done     = 1'b0;
      done_chk = 1'b0;
      rst      = 1'b0;
      wr(1'b0, '0, '0);
      rd(1'b1, 5'd5, 1'b1, 5'd6);

      // Reset held: outputs forced low even though the array is unswept.
      step();
      expect_out(K_READY, 32'd0, "rst_ready");
      expect_out(K_RD1,   32'd0, "rst_rd1");
      expect_out(K_RD2,   32'd0, "rst_rd2");
      step();
      step();

      // Release: ready_o low for exactly 31 cycles; write at cycle 10 is dropped.
      step();
      rst = 1'b1;
      for (int k = 0; k < 31; k++) begin
         if (k == 10) wr(1'b1, 5'd3, 32'h0000_A5A5);
         else         wr(1'b0, '0, '0);
         rd(1'b1, 5'(k + 1), 1'b1, 5'(31 - k));
         expect_out(K_READY, 32'd0, "init_ready");
         expect_out(K_RD1,   32'd0, "init_rd1");
         expect_out(K_RD2,   32'd0, "init_rd2");
         step();
      end
      wr(1'b0, '0, '0);
      expect_out(K_READY, 32'd1, "ready_rise");

      for (int i = 1; i < 32; i++) begin
         rd(1'b1, 5'(i), 1'b1, 5'(i));
         expect_out(K_RD1, 32'd0, "swept_rd1");
         expect_out(K_RD2, 32'd0, "swept_rd2");
         step();
      end

      // Write r5, read next cycle; disabled port returns 0.
      wr(1'b1, 5'd5, 32'hDEAD_BEEF);
      rd(1'b0, '0, 1'b0, '0);
      step();
      wr(1'b0, '0, '0);
      rd(1'b1, 5'd5, 1'b0, 5'd5);
      expect_out(K_RD1, 32'hDEAD_BEEF, "r5_rd1");
      expect_out(K_RD2, 32'd0,         "r5_rd2_disabled");
      step();

      // r0 write discarded, including no forwarding in the write cycle.
      wr(1'b1, 5'd0, 32'hFFFF_FFFF);
      rd(1'b1, 5'd0, 1'b1, 5'd0);
      expect_out(K_RD1, 32'd0, "r0_wrcyc_rd1");
      expect_out(K_RD2, 32'd0, "r0_wrcyc_rd2");
      step();
      wr(1'b0, '0, '0);
      expect_out(K_RD1, 32'd0, "r0_rd1");
      expect_out(K_RD2, 32'd0, "r0_rd2");
      step();

      // Same-cycle write/read of r7.
      wr(1'b1, 5'd7, 32'h0000_0001);
      rd(1'b0, '0, 1'b0, '0);
      step();
      wr(1'b1, 5'd7, 32'h0000_1234);
      rd(1'b1, 5'd7, 1'b1, 5'd7);
      expect_out(K_RD1, R7_SAME, "r7_same_rd1");
      expect_out(K_RD2, R7_SAME, "r7_same_rd2");
      step();
      wr(1'b0, '0, '0);
      expect_out(K_RD1, 32'h0000_1234, "r7_next_rd1");
      expect_out(K_RD2, 32'h0000_1234, "r7_next_rd2");
      step();

      // Async reset mid-cycle after writing r9.
      wr(1'b1, 5'd9, 32'h0000_0055);
      rd(1'b0, '0, 1'b0, '0);
      step();
      wr(1'b0, '0, '0);
      rd(1'b1, 5'd9, 1'b1, 5'd7);
      expect_out(K_RD1, 32'h0000_0055, "r9_rd1");
      expect_out(K_RD2, 32'h0000_1234, "r7_keep_rd2");
      step();
      #2;
      rst = 1'b0;
      expect_out(K_READY, 32'd0, "arst_ready");
      expect_out(K_RD1,   32'd0, "arst_rd1");
      expect_out(K_RD2,   32'd0, "arst_rd2");
      step();
      step();
      rst = 1'b1;
      for (int k = 0; k < 31; k++) begin
         expect_out(K_READY, 32'd0, "resweep_ready");
         expect_out(K_RD1,   32'd0, "resweep_rd1");
         step();
      end
      expect_out(K_READY, 32'd1, "resweep_rise");
      expect_out(K_RD1,   32'd0, "r9_cleared");
      expect_out(K_RD2,   32'd0, "r7_cleared");
      step();

      done = 1'b1;
      step();
      step();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
